// File: rtl/mem_ctrl_pkg.sv
// Shared types and helpers for the byte-serial memory controller.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

   typedef enum logic {OWN_IF = 1'b0, OWN_LS = 1'b1} owner_e;

   localparam logic [1:0] SZ_B      = 2'd0;
   localparam logic [1:0] SZ_H      = 2'd1;
   localparam logic [1:0] SZ_W      = 2'd2;
   localparam logic [1:0] IO_SEL_HI = 2'b11;

   // Size 3 is illegal and is handled as a full word.
   function automatic logic [2:0] size_bytes(input logic [1:0] sz);
      case (sz)
         SZ_B:    return 3'd1;
         SZ_H:    return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
      return w[{idx, 3'b000} +: 8];
   endfunction

   // Byte 0 starts a fresh result, so any bytes not filled later read as zero.
   function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                            input logic [7:0] b);
      logic [31:0] r;
      r = (idx == 2'd0) ? 32'd0 : w;
      r[{idx, 3'b000} +: 8] = b;
      return r;
   endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Fetch, load/store and memory-pin signals of the memory controller.
interface mem_ctrl_if;
   logic        rdy_in;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        flush_in;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic [31:0] ls_addr;
   logic [31:0] ls_wdata;
   logic        ls_done;
   logic [31:0] ls_rdata;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_buffer_full;

   modport slave (
      input  rdy_in, if_req, if_addr, flush_in, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      output if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );

   modport master (
      output rdy_in, if_req, if_addr, flush_in, ls_req, ls_we, ls_size, ls_addr, ls_wdata,
             mem_din, io_buffer_full,
      input  if_done, if_data, ls_done, ls_rdata, mem_dout, mem_a, mem_wr
   );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch and load/store onto the 8-bit memory port; 1/2/4-byte
// little-endian transfers with one-cycle read latency and I/O write throttling.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter logic [31:0] IO_BASE = {14'd0, IO_SEL_HI, 16'd0}
) (
   input  logic      clk_in,
   input  logic      rst_in,
   mem_ctrl_if.slave bus
);

   state_e      state;
   owner_e      owner;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  n_q;
   logic [2:0]  issue_cnt;
   logic        rd_act;
   logic        cap_vld;

   logic        acc_ls;
   logic        acc_if;
   logic        req_io;
   logic        addr_io;
   logic        wr_issue;
   logic        wr_can;
   logic        rd_issue;
   logic [2:0]  wr_next;
   logic [2:0]  rd_next;
   logic [1:0]  cap_idx;

   // NOTE: every signal here is assigned on every pass, so no latch can be inferred.
   always_comb begin
      acc_ls   = bus.ls_req;
      acc_if   = !bus.ls_req && bus.if_req && !bus.flush_in;
      req_io   = (bus.ls_addr[17:16] == IO_BASE[17:16]);
      addr_io  = (addr_q[17:16] == IO_BASE[17:16]);
      wr_issue = (state == WRITE) && bus.mem_wr && bus.rdy_in;
      wr_next  = issue_cnt + {2'b00, wr_issue};
      // An I/O byte may not follow an I/O byte written in the cycle just ending.
      wr_can   = !addr_io || (!bus.io_buffer_full && !wr_issue);
      rd_issue = (state == READ) && rd_act && bus.rdy_in;
      rd_next  = issue_cnt + 3'd1;
      // The byte being captured is the one issued on the previous edge.
      cap_idx  = issue_cnt[1:0] - 2'd1;
   end

   // NOTE: all state uses non-blocking assignments and is cleared by the async reset.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state        <= IDLE;
         owner        <= OWN_IF;
         addr_q       <= '0;
         wdata_q      <= '0;
         n_q          <= '0;
         issue_cnt    <= '0;
         rd_act       <= 1'b0;
         cap_vld      <= 1'b0;
         bus.mem_a    <= '0;
         bus.mem_dout <= '0;
         bus.mem_wr   <= 1'b0;
         bus.if_done  <= 1'b0;
         bus.ls_done  <= 1'b0;
         bus.if_data  <= '0;
         bus.ls_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               issue_cnt <= '0;
               cap_vld   <= 1'b0;
               rd_act    <= 1'b0;
               if (acc_ls) begin
                  owner   <= OWN_LS;
                  addr_q  <= bus.ls_addr;
                  wdata_q <= bus.ls_wdata;
                  n_q     <= size_bytes(bus.ls_size);
                  if (bus.ls_we) begin
                     state <= WRITE;
                     if (!req_io || !bus.io_buffer_full) begin
                        bus.mem_wr   <= 1'b1;
                        bus.mem_a    <= bus.ls_addr;
                        bus.mem_dout <= bus.ls_wdata[7:0];
                     end
                  end else begin
                     state     <= READ;
                     rd_act    <= 1'b1;
                     bus.mem_a <= bus.ls_addr;
                  end
               end else if (acc_if) begin
                  owner     <= OWN_IF;
                  addr_q    <= bus.if_addr;
                  n_q       <= 3'd4;
                  state     <= READ;
                  rd_act    <= 1'b1;
                  bus.mem_a <= bus.if_addr;
               end
            end

            READ: begin
               if (owner == OWN_IF && bus.flush_in) begin
                  state   <= IDLE;
                  rd_act  <= 1'b0;
                  cap_vld <= 1'b0;
               end else begin
                  cap_vld <= rd_issue;
                  if (rd_issue) begin
                     issue_cnt <= rd_next;
                     if (rd_next < n_q) bus.mem_a <= addr_q + {29'd0, rd_next};
                     else               rd_act    <= 1'b0;
                  end
                  if (cap_vld) begin
                     if (owner == OWN_LS) bus.ls_rdata <= put_byte(bus.ls_rdata, cap_idx, bus.mem_din);
                     else                 bus.if_data  <= put_byte(bus.if_data, cap_idx, bus.mem_din);
                     if (issue_cnt == n_q) begin
                        state <= DONE;
                        if (owner == OWN_LS) bus.ls_done <= 1'b1;
                        else                 bus.if_done <= 1'b1;
                     end
                  end
               end
            end

            WRITE: begin
               issue_cnt <= wr_next;
               if (wr_issue && wr_next == n_q) begin
                  state       <= DONE;
                  bus.ls_done <= 1'b1;
                  bus.mem_wr  <= 1'b0;
               end else if (wr_can) begin
                  bus.mem_wr   <= 1'b1;
                  bus.mem_a    <= addr_q + {29'd0, wr_next};
                  bus.mem_dout <= get_byte(wdata_q, wr_next[1:0]);
               end else begin
                  bus.mem_wr <= 1'b0;
               end
            end

            DONE: begin
               bus.if_done <= 1'b0;
               bus.ls_done <= 1'b0;
               state       <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed vector table plus corner-case sequences
// against a byte RAM with one-cycle read latency and an I/O write log.
module tb_mem_ctrl;
   import mem_ctrl_pkg::*;

   logic clk_in = 1'b0;
   logic rst_in = 1'b0;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   logic [7:0]  ram [0:65535] = '{default: 8'h00};
   int          io_wr_cnt = 0;
   int          io_last_cyc = 0;
   int          io_prev_cyc = 0;
   logic [7:0]  io_last_val = 8'h00;

   mem_ctrl_if bus();

   mem_ctrl #(.IO_BASE(32'h0003_0000)) dut (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .bus    (bus)
   );

   always #5 clk_in = ~clk_in;

   // RAM returns the addressed byte one cycle later; junk while HCI owns the bus.
   always @(posedge clk_in) begin
      cyc <= cyc + 1;
      if (bus.rdy_in) begin
         if (bus.mem_wr) begin
            if (bus.mem_a[17:16] == 2'b11) begin
               io_wr_cnt   <= io_wr_cnt + 1;
               io_prev_cyc <= io_last_cyc;
               io_last_cyc <= cyc;
               io_last_val <= bus.mem_dout;
            end else begin
               ram[bus.mem_a[15:0]] <= bus.mem_dout;
            end
         end
         bus.mem_din <= ram[bus.mem_a[15:0]];
      end else begin
         bus.mem_din <= 8'hEE;
      end
   end

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_mem_a"},    bus.mem_a, 32'h0);
      check({tag, "_mem_dout"}, 32'(bus.mem_dout), 32'h0);
      check({tag, "_mem_wr"},   32'(bus.mem_wr), 32'h0);
      check({tag, "_if_done"},  32'(bus.if_done), 32'h0);
      check({tag, "_ls_done"},  32'(bus.ls_done), 32'h0);
      check({tag, "_if_data"},  bus.if_data, 32'h0);
      check({tag, "_ls_rdata"}, bus.ls_rdata, 32'h0);
   endtask

   // Called at a negedge in an IDLE cycle (cycle 0); returns the cycle of ls_done.
   task automatic run_ls(input logic we, input logic [1:0] size, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat, output logic [31:0] rdata);
      lat   = -1;
      rdata = '0;
      bus.ls_we    = we;
      bus.ls_size  = size;
      bus.ls_addr  = addr;
      bus.ls_wdata = wdata;
      bus.ls_req   = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk_in);
         if (bus.ls_done) begin
            lat   = c;
            rdata = bus.ls_rdata;
            break;
         end
      end
      bus.ls_req = 1'b0;
      @(negedge clk_in);
   endtask

   initial begin
      int          lat;
      int          n0;
      int          ls_c;
      int          if_c;
      logic [31:0] rd;
      logic [31:0] if_d;
      logic [31:0] a_snap;
      logic        seen;

      bus.rdy_in = 1'b1;          bus.if_req = 1'b0;      bus.if_addr = '0;
      bus.flush_in = 1'b0;        bus.ls_req = 1'b0;      bus.ls_we = 1'b0;
      bus.ls_size = SZ_W;         bus.ls_addr = '0;       bus.ls_wdata = '0;
      bus.io_buffer_full = 1'b0;

      vecs[0]  = '{1'b1, SZ_W,  32'h0000_0100, 32'h1122_3344, 32'h0,         5};
      vecs[1]  = '{1'b0, SZ_W,  32'h0000_0100, 32'h0,         32'h1122_3344, 6};
      vecs[2]  = '{1'b1, SZ_H,  32'h0000_0200, 32'hAAAA_BEEF, 32'h0,         3};
      vecs[3]  = '{1'b1, SZ_B,  32'h0000_0203, 32'h1234_567F, 32'h0,         2};
      vecs[4]  = '{1'b0, SZ_W,  32'h0000_0200, 32'h0,         32'h7F00_BEEF, 6};
      vecs[5]  = '{1'b0, SZ_B,  32'h0000_0203, 32'h0,         32'h0000_007F, 3};
      vecs[6]  = '{1'b0, SZ_H,  32'h0000_0202, 32'h0,         32'h0000_7F00, 4};
      vecs[7]  = '{1'b0, 2'd3,  32'h0000_0100, 32'h0,         32'h1122_3344, 6};
      vecs[8]  = '{1'b0, SZ_H,  32'h0000_0101, 32'h0,         32'h0000_2233, 4};
      vecs[9]  = '{1'b1, SZ_W,  32'h0000_1000, 32'h0000_0513, 32'h0,         5};
      vecs[10] = '{1'b1, SZ_H,  32'h0000_2002, 32'h5555_CDAB, 32'h0,         3};
      vecs[11] = '{1'b1, SZ_H,  32'h0003_0000, 32'h0000_4443, 32'h0,         4};

      repeat (3) @(negedge clk_in);
      check_reset_outputs("reset");
      rst_in = 1'b1;
      @(negedge clk_in);

      for (int i = 0; i < 12; i++) begin
         run_ls(vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata, lat, rd);
         check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
         if (!vecs[i].we) check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      end
      check("io_half_write_count", 32'(io_wr_cnt), 32'd2);
      check("io_half_byte_gap", 32'(io_last_cyc - io_prev_cyc), 32'd2);
      check("io_half_last_byte", 32'(io_last_val), 32'h44);

      // Fetch word: bytes issued at 0x1000..0x1003, done in cycle 6.
      bus.if_addr = 32'h0000_1000;
      bus.if_req  = 1'b1;
      if_c = -1;
      if_d = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_in);
         if (c <= 4) check($sformatf("fetch_mem_a_c%0d", c), bus.mem_a, 32'h0000_1000 + 32'(c - 1));
         if (bus.if_done) begin
            if_c = c;
            if_d = bus.if_data;
            break;
         end
      end
      bus.if_req = 1'b0;
      @(negedge clk_in);
      check("fetch_done_cycle", 32'(if_c), 32'd6);
      check("fetch_data", if_d, 32'h0000_0513);

      // Simultaneous requests: load/store first, fetch accepted after DONE.
      bus.if_addr = 32'h0000_1000;
      bus.if_req  = 1'b1;
      bus.ls_we = 1'b0;  bus.ls_size = SZ_H;  bus.ls_addr = 32'h0000_2002;
      bus.ls_req  = 1'b1;
      ls_c = -1;  if_c = -1;  rd = '0;  if_d = '0;  a_snap = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_in);
         if (bus.ls_done && ls_c < 0) begin
            ls_c = c;
            rd   = bus.ls_rdata;
            bus.ls_req = 1'b0;
         end
         if (c == 6) a_snap = bus.mem_a;
         if (bus.if_done) begin
            if_c = c;
            if_d = bus.if_data;
            break;
         end
      end
      bus.if_req = 1'b0;
      bus.ls_req = 1'b0;
      @(negedge clk_in);
      check("arb_ls_done_cycle", 32'(ls_c), 32'd4);
      check("arb_ls_rdata", rd, 32'h0000_CDAB);
      check("arb_fetch_first_addr", a_snap, 32'h0000_1000);
      check("arb_if_done_cycle", 32'(if_c), 32'd11);
      check("arb_if_data", if_d, 32'h0000_0513);

      // I/O store throttled by io_buffer_full for three edges.
      n0 = io_wr_cnt;
      bus.io_buffer_full = 1'b1;
      bus.ls_we = 1'b1;  bus.ls_size = SZ_B;
      bus.ls_addr = 32'h0003_0000;  bus.ls_wdata = 32'h0000_0041;
      bus.ls_req = 1'b1;
      ls_c = -1;  seen = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_in);
         if (c <= 3) seen = seen | bus.mem_wr;
         if (c == 3) bus.io_buffer_full = 1'b0;
         if (c == 4) begin
            check("io_thr_mem_wr", 32'(bus.mem_wr), 32'd1);
            check("io_thr_mem_a", bus.mem_a, 32'h0003_0000);
            check("io_thr_mem_dout", 32'(bus.mem_dout), 32'h41);
         end
         if (bus.ls_done) begin
            ls_c = c;
            break;
         end
      end
      bus.ls_req = 1'b0;
      @(negedge clk_in);
      check("io_thr_wr_while_full", 32'(seen), 32'd0);
      check("io_thr_done_cycle", 32'(ls_c), 32'd5);
      check("io_thr_write_count", 32'(io_wr_cnt - n0), 32'd1);
      run_ls(1'b1, SZ_B, 32'h0003_0000, 32'h0000_0042, lat, rd);
      check("io_next_latency", 32'(lat), 32'd2);
      check("io_next_value", 32'(io_last_val), 32'h42);
      check("io_next_gap_ok", 32'((io_last_cyc - io_prev_cyc) >= 2), 32'd1);

      // rdy_in low on the edges ending cycles 3 and 4 of a word load.
      bus.ls_we = 1'b0;  bus.ls_size = SZ_W;  bus.ls_addr = 32'h0000_0100;
      bus.ls_req = 1'b1;
      ls_c = -1;  rd = '0;  a_snap = '0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_in);
         if (c == 3) bus.rdy_in = 1'b0;
         if (c == 5) begin
            a_snap = bus.mem_a;
            bus.rdy_in = 1'b1;
         end
         if (bus.ls_done) begin
            ls_c = c;
            rd   = bus.ls_rdata;
            break;
         end
      end
      bus.rdy_in = 1'b1;
      bus.ls_req = 1'b0;
      @(negedge clk_in);
      check("stall_held_addr", a_snap, 32'h0000_0102);
      check("stall_done_cycle", 32'(ls_c), 32'd8);
      check("stall_rdata", rd, 32'h1122_3344);

      // Flush in cycle 3 of a fetch while a load is pending.
      bus.if_addr = 32'h0000_1000;
      bus.if_req  = 1'b1;
      ls_c = -1;  rd = '0;  a_snap = '0;  seen = 1'b0;
      for (int c = 1; c <= 30; c++) begin
         @(negedge clk_in);
         seen = seen | bus.if_done;
         if (c == 2) begin
            bus.ls_we = 1'b0;  bus.ls_size = SZ_B;  bus.ls_addr = 32'h0000_0100;
            bus.ls_req = 1'b1;
         end
         if (c == 3) begin
            bus.flush_in = 1'b1;
            bus.if_req   = 1'b0;
         end
         if (c == 4) bus.flush_in = 1'b0;
         if (c == 5) a_snap = bus.mem_a;
         if (bus.ls_done) begin
            ls_c = c;
            rd   = bus.ls_rdata;
            break;
         end
      end
      bus.ls_req = 1'b0;
      bus.flush_in = 1'b0;
      repeat (3) begin
         @(negedge clk_in);
         seen = seen | bus.if_done;
      end
      check("flush_no_if_done", 32'(seen), 32'd0);
      check("flush_ls_first_addr", a_snap, 32'h0000_0100);
      check("flush_ls_done_cycle", 32'(ls_c), 32'd7);
      check("flush_ls_rdata", rd, 32'h0000_0044);

      // Reset during byte 2 of a word store; bytes 0 and 1 remain written.
      bus.ls_we = 1'b1;  bus.ls_size = SZ_W;
      bus.ls_addr = 32'h0000_0300;  bus.ls_wdata = 32'hA1B2_C3D4;
      bus.ls_req = 1'b1;
      repeat (3) @(negedge clk_in);
      check("rst_pre_mem_a", bus.mem_a, 32'h0000_0302);
      check("rst_pre_mem_wr", 32'(bus.mem_wr), 32'd1);
      rst_in = 1'b0;
      #1;
      check_reset_outputs("midreset");
      bus.ls_req = 1'b0;
      @(negedge clk_in);
      rst_in = 1'b1;
      @(negedge clk_in);
      run_ls(1'b0, SZ_W, 32'h0000_0300, 32'h0, lat, rd);
      check("post_rst_latency", 32'(lat), 32'd6);
      check("post_rst_rdata", rd, 32'h0000_C3D4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
